spi_minion_core: RTL

SPI mode-0 minion (responder) that pairs with the team's SPI master, which initiates all transfers.
- Oversamples the raw SPI pins (chip select, serial clock, MOSI) in the system clock domain.
- Shifts in one `nbits` frame per chip-select assertion and shifts a preloaded reply out on MISO.
- Delivers the received word through a push interface and fetches the outgoing word through a pull interface.
- Sits between the chip pins and the minion-side adapter/FIFO logic.

---
 rtl/spi_minion_core.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/spi_minion_core.sv
// SPI mode-0 minion: oversamples the raw pins in the clk domain and shifts one
// nbits frame per chip-select assertion, MSB first on both MOSI and MISO.
module spi_minion_core #(
    parameter int nbits = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             spi_cs,
    input  logic             spi_sclk,
    input  logic             spi_mosi,
    output logic             spi_miso,
    output logic             pull_en,
    input  logic [nbits-1:0] pull_msg,
    output logic             push_en,
    output logic [nbits-1:0] push_msg
);

    localparam int CW = $clog2(nbits + 1);
    localparam logic [CW-1:0] LAST_BIT = CW'(nbits - 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic             cs_meta_r, cs_sync_r, cs_prev_r;
    logic             sclk_meta_r, sclk_sync_r, sclk_prev_r;
    logic             mosi_meta_r, mosi_sync_r;
    logic [nbits-1:0] tx_r;
    logic [nbits-1:0] rx_r;
    logic [CW-1:0]    cnt_r;
    logic             push_en_r;
    logic             cs_fall_s, cs_rise_s, sclk_rise_s, sclk_fall_s;
    logic             load_s, shift_in_s, shift_out_s, push_set_s;

    // Two-flop synchronizers plus a history flop on cs and sclk for edge detection
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cs_meta_r   <= 1'b1;
            cs_sync_r   <= 1'b1;
            cs_prev_r   <= 1'b1;
            sclk_meta_r <= 1'b0;
            sclk_sync_r <= 1'b0;
            sclk_prev_r <= 1'b0;
            mosi_meta_r <= 1'b0;
            mosi_sync_r <= 1'b0;
        end else begin
            cs_meta_r   <= spi_cs;
            cs_sync_r   <= cs_meta_r;
            cs_prev_r   <= cs_sync_r;
            sclk_meta_r <= spi_sclk;
            sclk_sync_r <= sclk_meta_r;
            sclk_prev_r <= sclk_sync_r;
            mosi_meta_r <= spi_mosi;
            mosi_sync_r <= mosi_meta_r;
        end
    end

    assign cs_fall_s   =  cs_prev_r   & ~cs_sync_r;
    assign cs_rise_s   = ~cs_prev_r   &  cs_sync_r;
    assign sclk_rise_s = ~sclk_prev_r &  sclk_sync_r;
    assign sclk_fall_s =  sclk_prev_r & ~sclk_sync_r;

    // Frame state register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state and datapath control; cs_rise outranks any sclk edge
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        shift_in_s  = 1'b0;
        shift_out_s = 1'b0;
        push_set_s  = 1'b0;
        case (state_r)
            IDLE: begin
                if (cs_fall_s) begin
                    state_nxt_s = ACTIVE;
                    load_s      = 1'b1;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            ACTIVE: begin
                if (cs_rise_s) begin
                    state_nxt_s = IDLE;
                end else if (sclk_rise_s) begin
                    shift_in_s = 1'b1;
                    if (cnt_r == LAST_BIT) begin
                        state_nxt_s = DONE;
                        push_set_s  = 1'b1;
                    end else begin
                        state_nxt_s = ACTIVE;
                    end
                end else if (sclk_fall_s) begin
                    shift_out_s = 1'b1;
                end else begin
                    state_nxt_s = ACTIVE;
                end
            end
            DONE: begin
                if (cs_rise_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = DONE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Shift registers, bit counter and the registered push strobe
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_r      <= '0;
            rx_r      <= '0;
            cnt_r     <= '0;
            push_en_r <= 1'b0;
        end else begin
            push_en_r <= push_set_s;
            if (load_s) begin
                tx_r  <= pull_msg;
                rx_r  <= '0;
                cnt_r <= '0;
            end else begin
                if (shift_in_s) begin
                    rx_r  <= {rx_r[nbits-2:0], mosi_sync_r};
                    cnt_r <= cnt_r + CW'(1);
                end
                if (shift_out_s) begin
                    tx_r <= {tx_r[nbits-2:0], 1'b0};
                end
            end
        end
    end

    assign pull_en  = load_s;
    assign push_en  = push_en_r;
    assign push_msg = rx_r;
    assign spi_miso = (state_r != IDLE) ? tx_r[nbits-1] : 1'b0;

endmodule
